// File: rtl/parking_gate_if.sv
// parking_gate_if: gate sensor requests and arbiter status between requesters and the gate arbiter.
interface parking_gate_if #(
    parameter int NUM_SPOTS = 4,
    parameter int SPOT_W = 2,
    parameter int CNT_W = 3
);
    logic entry_req;
    logic exit_req;
    logic [SPOT_W-1:0] exit_spot;
    logic entry_grant;
    logic exit_grant;
    logic exit_err;
    logic [SPOT_W-1:0] assigned_spot;
    logic door_open;
    logic [NUM_SPOTS-1:0] occupancy;
    logic [CNT_W-1:0] free_count;
    logic full;
    logic empty;
    modport master (
        output entry_req, exit_req, exit_spot,
        input entry_grant, exit_grant, exit_err, assigned_spot, door_open, occupancy, free_count, full, empty
    );
    modport slave (
        input entry_req, exit_req, exit_spot,
        output entry_grant, exit_grant, exit_err, assigned_spot, door_open, occupancy, free_count, full, empty
    );
endinterface

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: round-robin entry/exit arbitration for one gate, spot map and door-open timing.
module parking_gate_arbiter #(
    parameter int NUM_SPOTS = 4,
    parameter int SPOT_W = 2,
    parameter int CNT_W = 3,
    parameter int OPEN_CYCLES = 8
) (
    input logic clk_i,
    input logic rst_ni,
    parking_gate_if.slave gate
);
    localparam int TW = $clog2(OPEN_CYCLES);
    typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, GUARD} state_t;
    state_t state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [NUM_SPOTS-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] free_q, free_d;
    logic [SPOT_W-1:0] spot_q, spot_d, exit_spot_q, free_idx;
    logic entry_req_q, exit_req_q, last_entry_q, last_entry_d;
    logic eg_q, eg_d, xg_q, xg_d, err_q, err_d;
    logic full, exit_seen, exit_ok, entry_ok, take_entry;
    assign full = free_q == '0;
    // a request still registered while its error pulse is out is the one just rejected
    assign exit_seen = exit_req_q && !err_q;
    assign exit_ok = exit_seen && occ_q[exit_spot_q];
    assign entry_ok = entry_req_q && !full;
    assign take_entry = entry_ok && !(exit_ok && last_entry_q);
    always_comb begin
        free_idx = '0;
        for (int i = NUM_SPOTS - 1; i >= 0; i--)
            if (!occ_q[i]) free_idx = SPOT_W'(i);
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        occ_d = occ_q;
        free_d = free_q;
        spot_d = spot_q;
        last_entry_d = last_entry_q;
        eg_d = 1'b0;
        xg_d = 1'b0;
        err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (exit_seen && !exit_ok) begin
                    err_d = 1'b1;
                end else if (take_entry) begin
                    state_d = OPEN_IN;
                    cnt_d = TW'(OPEN_CYCLES - 1);
                    eg_d = 1'b1;
                    spot_d = free_idx;
                    occ_d[free_idx] = 1'b1;
                    free_d = free_q - CNT_W'(1);
                    last_entry_d = 1'b1;
                end else if (exit_ok) begin
                    state_d = OPEN_OUT;
                    cnt_d = TW'(OPEN_CYCLES - 1);
                    xg_d = 1'b1;
                    occ_d[exit_spot_q] = 1'b0;
                    free_d = free_q + CNT_W'(1);
                    last_entry_d = 1'b0;
                end
            end
            OPEN_IN, OPEN_OUT: begin
                if (cnt_q == '0) state_d = GUARD;
                else cnt_d = cnt_q - TW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q <= '0;
            occ_q <= '0;
            free_q <= CNT_W'(NUM_SPOTS);
            spot_q <= '0;
            last_entry_q <= 1'b0;
            eg_q <= 1'b0;
            xg_q <= 1'b0;
            err_q <= 1'b0;
            entry_req_q <= 1'b0;
            exit_req_q <= 1'b0;
            exit_spot_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            occ_q <= occ_d;
            free_q <= free_d;
            spot_q <= spot_d;
            last_entry_q <= last_entry_d;
            eg_q <= eg_d;
            xg_q <= xg_d;
            err_q <= err_d;
            entry_req_q <= gate.entry_req;
            exit_req_q <= gate.exit_req;
            exit_spot_q <= gate.exit_spot;
        end
    end
    assign gate.entry_grant = eg_q;
    assign gate.exit_grant = xg_q;
    assign gate.exit_err = err_q;
    assign gate.assigned_spot = spot_q;
    assign gate.door_open = state_q == OPEN_IN || state_q == OPEN_OUT;
    assign gate.occupancy = occ_q;
    assign gate.free_count = free_q;
    assign gate.full = full;
    assign gate.empty = free_q == CNT_W'(NUM_SPOTS);
endmodule
